// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM states, datapath select codes,
// data-processing commands, condition codes and the condition-check function.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH
  } state_e;

  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluSub = 2'b01;
  localparam logic [1:0] AluAnd = 2'b10;
  localparam logic [1:0] AluOrr = 2'b11;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] SrcBWriteData = 2'b00;
  localparam logic [1:0] SrcBExtImm    = 2'b01;
  localparam logic [1:0] SrcBFour      = 2'b10;

  localparam logic [1:0] Imm8  = 2'b00;
  localparam logic [1:0] Imm12 = 2'b01;
  localparam logic [1:0] Imm24 = 2'b10;

  // funct[4:1] data-processing commands
  localparam logic [3:0] CmdAnd = 4'b0000;
  localparam logic [3:0] CmdSub = 4'b0010;
  localparam logic [3:0] CmdAdd = 4'b0100;
  localparam logic [3:0] CmdTst = 4'b1000;
  localparam logic [3:0] CmdCmp = 4'b1010;
  localparam logic [3:0] CmdOrr = 4'b1100;

  localparam logic [3:0] CondEq = 4'h0;
  localparam logic [3:0] CondNe = 4'h1;
  localparam logic [3:0] CondCs = 4'h2;
  localparam logic [3:0] CondCc = 4'h3;
  localparam logic [3:0] CondMi = 4'h4;
  localparam logic [3:0] CondPl = 4'h5;
  localparam logic [3:0] CondVs = 4'h6;
  localparam logic [3:0] CondVc = 4'h7;
  localparam logic [3:0] CondHi = 4'h8;
  localparam logic [3:0] CondLs = 4'h9;
  localparam logic [3:0] CondGe = 4'hA;
  localparam logic [3:0] CondLt = 4'hB;
  localparam logic [3:0] CondGt = 4'hC;
  localparam logic [3:0] CondLe = 4'hD;
  localparam logic [3:0] CondAl = 4'hE;

  // flags is {N,Z,C,V}; the never-code (1111) falls through to 0
  function automatic logic condcheck(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v, ge;
    logic res;
    {n, z, c, v} = flags;
    ge = (n == v);
    case (cond)
      CondEq:  res = z;
      CondNe:  res = ~z;
      CondCs:  res = c;
      CondCc:  res = ~c;
      CondMi:  res = n;
      CondPl:  res = ~n;
      CondVs:  res = v;
      CondVc:  res = ~v;
      CondHi:  res = c & ~z;
      CondLs:  res = ~(c & ~z);
      CondGe:  res = ge;
      CondLt:  res = ~ge;
      CondGt:  res = ~z & ge;
      CondLe:  res = ~(~z & ge);
      CondAl:  res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/arm_mc_condunit.sv
// NZCV flag register, condition check latched in DECODE, and the per-command
// NoWrite / flag-write-enable decode.
module arm_mc_condunit import arm_mc_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond_i,
  input  logic [5:0] funct_i,
  input  logic       decode_i,
  input  logic       execute_i,
  input  logic [3:0] alu_flags_i,
  output logic       cond_q_o,
  output logic       no_write_o
);

  logic [3:0] flags_q, flags_d;
  logic       cond_q, cond_d;
  logic [3:0] cmd;
  logic       s_bit;
  logic [1:0] flag_w;

  assign cmd   = funct_i[4:1];
  assign s_bit = funct_i[0];

  always_comb begin
    no_write_o = 1'b1;
    case (cmd)
      CmdAdd, CmdSub, CmdAnd, CmdOrr: no_write_o = 1'b0;
      default:                        no_write_o = 1'b1;
    endcase
    // C and V only come from the adder, so logical ops leave them alone
    flag_w[1] = s_bit;
    flag_w[0] = s_bit & ((cmd == CmdAdd) | (cmd == CmdSub) | (cmd == CmdCmp));
  end

  always_comb begin
    flags_d = flags_q;
    cond_d  = cond_q;
    if (decode_i) cond_d = condcheck(cond_i, flags_q);
    if (execute_i && cond_q) begin
      if (flag_w[1]) flags_d[3:2] = alu_flags_i[3:2];
      if (flag_w[0]) flags_d[1:0] = alu_flags_i[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
      cond_q  <= 1'b0;
    end else begin
      flags_q <= flags_d;
      cond_q  <= cond_d;
    end
  end

  assign cond_q_o = cond_q;

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: main FSM driving datapath selects and write enables,
// with flag/condition handling delegated to arm_mc_condunit.
module arm_mc_controller import arm_mc_pkg::*; (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  output logic         PCWrite,
  output logic         AdrSrc,
  output logic         MemWrite,
  output logic         IRWrite,
  output logic         RegWrite,
  output logic [1:0]   ResultSrc,
  output logic         ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ALUControl,
  output logic [1:0]   ImmSrc,
  output logic [1:0]   RegSrc,
  output logic         Done
);

  state_e     state_q, state_d;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       rd_is_pc;
  logic       cond_q;
  logic       no_write;
  logic       pc_write, mem_write, ir_write, reg_write;
  logic [1:0] alu_ctrl_dp;
  logic       unused_rn;

  assign op        = Instr[27:26];
  assign funct     = Instr[25:20];
  assign rd        = Instr[15:12];
  assign rd_is_pc  = (rd == 4'hF);
  assign unused_rn = ^Instr[19:16];

  arm_mc_condunit u_cond (
    .clk         (clk),
    .reset       (reset),
    .cond_i      (Instr[31:28]),
    .funct_i     (funct),
    .decode_i    (state_q == DECODE),
    .execute_i   ((state_q == EXECUTER) || (state_q == EXECUTEI)),
    .alu_flags_i (ALUFlags),
    .cond_q_o    (cond_q),
    .no_write_o  (no_write)
  );

  always_comb begin
    case (funct[4:1])
      CmdSub, CmdCmp: alu_ctrl_dp = AluSub;
      CmdAnd, CmdTst: alu_ctrl_dp = AluAnd;
      CmdOrr:         alu_ctrl_dp = AluOrr;
      default:        alu_ctrl_dp = AluAdd;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = ResAluOut;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SrcBWriteData;
    ALUControl = AluAdd;
    ImmSrc     = Imm8;
    RegSrc     = 2'b00;
    Done       = 1'b0;
    unique case (state_q)
      FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAluResult;
        state_d   = DECODE;
      end
      DECODE: begin
        // PC+4 again here presents PC+8 as R15 to the register file read
        ALUSrcA   = 1'b1;
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAluResult;
        unique case (op)
          2'b00: state_d = funct[5] ? EXECUTEI : EXECUTER;
          2'b01: state_d = MEMADR;
          2'b10: state_d = BRANCH;
          2'b11: begin
            state_d = FETCH;
            Done    = 1'b1;
          end
          default: state_d = FETCH;
        endcase
      end
      EXECUTER, EXECUTEI: begin
        ALUSrcB    = (state_q == EXECUTEI) ? SrcBExtImm : SrcBWriteData;
        ALUControl = alu_ctrl_dp;
        state_d    = ALUWB;
      end
      ALUWB: begin
        reg_write = cond_q & ~no_write;
        pc_write  = cond_q & ~no_write & rd_is_pc;
        Done      = 1'b1;
        state_d   = FETCH;
      end
      MEMADR: begin
        ALUSrcB = SrcBExtImm;
        ImmSrc  = Imm12;
        state_d = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = ResData;
        reg_write = cond_q;
        pc_write  = cond_q & rd_is_pc;
        Done      = 1'b1;
        state_d   = FETCH;
      end
      MEMWR: begin
        AdrSrc    = 1'b1;
        RegSrc    = 2'b10;
        mem_write = cond_q;
        Done      = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        RegSrc    = 2'b01;
        ALUSrcB   = SrcBExtImm;
        ImmSrc    = Imm24;
        ResultSrc = ResAluResult;
        pc_write  = cond_q;
        Done      = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Architectural writes are blocked for as long as reset is held
  assign PCWrite  = pc_write & ~reset;
  assign MemWrite = mem_write & ~reset;
  assign IRWrite  = ir_write & ~reset;
  assign RegWrite = reg_write & ~reset;

endmodule

// File: tb/tb_arm_mc_controller.sv
// Directed bench for arm_mc_controller: per-cycle expected control vectors per instruction.
module tb_arm_mc_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] Instr = '0;
  logic [3:0]  ALUFlags = '0;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, Done;
  logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [16:0] ctrl;

  int n_cmp = 0;
  int n_err = 0;

  arm_mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .Done       (Done)
  );

  always #5 clk = ~clk;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,RegSrc,Done}
  assign ctrl = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                 ALUControl, ImmSrc, RegSrc, Done};

  localparam logic [16:0] V_FETCH    = 17'b1_0_0_1_0_10_1_10_00_00_00_0;
  localparam logic [16:0] V_DEC      = 17'b0_0_0_0_0_10_1_10_00_00_00_0;
  localparam logic [16:0] V_DEC_DONE = 17'b0_0_0_0_0_10_1_10_00_00_00_1;
  localparam logic [16:0] V_EXI_ADD  = 17'b0_0_0_0_0_00_0_01_00_00_00_0;
  localparam logic [16:0] V_EXR_ADD  = 17'b0_0_0_0_0_00_0_00_00_00_00_0;
  localparam logic [16:0] V_EXR_SUB  = 17'b0_0_0_0_0_00_0_00_01_00_00_0;
  localparam logic [16:0] V_EXR_AND  = 17'b0_0_0_0_0_00_0_00_10_00_00_0;
  localparam logic [16:0] V_EXR_ORR  = 17'b0_0_0_0_0_00_0_00_11_00_00_0;
  localparam logic [16:0] V_WB_W     = 17'b0_0_0_0_1_00_0_00_00_00_00_1;
  localparam logic [16:0] V_WB_PC    = 17'b1_0_0_0_1_00_0_00_00_00_00_1;
  localparam logic [16:0] V_WB_NONE  = 17'b0_0_0_0_0_00_0_00_00_00_00_1;
  localparam logic [16:0] V_MADR     = 17'b0_0_0_0_0_00_0_01_00_01_00_0;
  localparam logic [16:0] V_MRD      = 17'b0_1_0_0_0_00_0_00_00_00_00_0;
  localparam logic [16:0] V_MWB_PC   = 17'b1_0_0_0_1_01_0_00_00_00_00_1;
  localparam logic [16:0] V_MWR      = 17'b0_1_1_0_0_00_0_00_00_00_10_1;
  localparam logic [16:0] V_BR_T     = 17'b1_0_0_0_0_10_0_01_00_10_01_1;
  localparam logic [16:0] V_BR_N     = 17'b0_0_0_0_0_10_0_01_00_10_01_1;
  // FETCH while reset is still high: write enables masked off
  localparam logic [16:0] V_FETCH_RST = 17'b0_0_0_0_0_10_1_10_00_00_00_0;

  task automatic test_reset();
    logic [40:0] t [$];
    reset = 1'b1;
    Instr = 20'hE2802;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({PCWrite, MemWrite, IRWrite, RegWrite} !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_gate cycle %0d: writes=%b expected 0000", c,
                 {PCWrite, MemWrite, IRWrite, RegWrite});
      end
    end
    reset = 1'b0;
    // ADD R2,R0,#5
    t = '{{20'hE2802, 4'h0, V_FETCH}, {20'hE2802, 4'h0, V_DEC},
          {20'hE2802, 4'h0, V_EXI_ADD}, {20'hE2802, 4'h0, V_WB_W}};
    foreach (t[i]) begin
      Instr = t[i][40:21]; ALUFlags = t[i][20:17];
      #1; n_cmp++;
      if (ctrl !== t[i][16:0]) begin
        n_err++;
        $display("FAIL reset_add cycle %0d: ctrl=%b expected %b", i, ctrl, t[i][16:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_subs_addne();
    logic [40:0] t [$];
    // SUBS R3,R2,R1 sets Z; ADDNE then fails its condition
    t = '{{20'hE0523, 4'h4, V_FETCH}, {20'hE0523, 4'h4, V_DEC},
          {20'hE0523, 4'h4, V_EXR_SUB}, {20'hE0523, 4'h4, V_WB_W},
          {20'h10833, 4'hF, V_FETCH}, {20'h10833, 4'hF, V_DEC},
          {20'h10833, 4'hF, V_EXR_ADD}, {20'h10833, 4'hF, V_WB_NONE}};
    foreach (t[i]) begin
      Instr = t[i][40:21]; ALUFlags = t[i][20:17];
      #1; n_cmp++;
      if (ctrl !== t[i][16:0]) begin
        n_err++;
        $display("FAIL subs_addne cycle %0d: ctrl=%b expected %b", i, ctrl, t[i][16:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_cmp_beq();
    logic [40:0] t [$];
    // CMP leaves Z=1,C=1; BEQ and BCS taken, BMI not
    t = '{{20'hE1510, 4'h6, V_FETCH}, {20'hE1510, 4'h6, V_DEC},
          {20'hE1510, 4'h6, V_EXR_SUB}, {20'hE1510, 4'h6, V_WB_NONE},
          {20'h0A000, 4'h0, V_FETCH}, {20'h0A000, 4'h0, V_DEC}, {20'h0A000, 4'h0, V_BR_T},
          {20'h2A000, 4'h0, V_FETCH}, {20'h2A000, 4'h0, V_DEC}, {20'h2A000, 4'h0, V_BR_T},
          {20'h4A000, 4'h0, V_FETCH}, {20'h4A000, 4'h0, V_DEC}, {20'h4A000, 4'h0, V_BR_N}};
    foreach (t[i]) begin
      Instr = t[i][40:21]; ALUFlags = t[i][20:17];
      #1; n_cmp++;
      if (ctrl !== t[i][16:0]) begin
        n_err++;
        $display("FAIL cmp_beq cycle %0d: ctrl=%b expected %b", i, ctrl, t[i][16:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem();
    logic [40:0] t [$];
    // STR, LDR PC, ADD PC,#imm, ORR
    t = '{{20'hE5812, 4'h0, V_FETCH}, {20'hE5812, 4'h0, V_DEC},
          {20'hE5812, 4'h0, V_MADR}, {20'hE5812, 4'h0, V_MWR},
          {20'hE591F, 4'h0, V_FETCH}, {20'hE591F, 4'h0, V_DEC}, {20'hE591F, 4'h0, V_MADR},
          {20'hE591F, 4'h0, V_MRD}, {20'hE591F, 4'h0, V_MWB_PC},
          {20'hE280F, 4'h0, V_FETCH}, {20'hE280F, 4'h0, V_DEC},
          {20'hE280F, 4'h0, V_EXI_ADD}, {20'hE280F, 4'h0, V_WB_PC},
          {20'hE1833, 4'h0, V_FETCH}, {20'hE1833, 4'h0, V_DEC},
          {20'hE1833, 4'h0, V_EXR_ORR}, {20'hE1833, 4'h0, V_WB_W}};
    foreach (t[i]) begin
      Instr = t[i][40:21]; ALUFlags = t[i][20:17];
      #1; n_cmp++;
      if (ctrl !== t[i][16:0]) begin
        n_err++;
        $display("FAIL mem cycle %0d: ctrl=%b expected %b", i, ctrl, t[i][16:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ands();
    logic [40:0] t [$];
    // CMP sets 1001, ANDS with 0110 gives 0101; then probe EQ/CS/VS/NV and op=11
    t = '{{20'hE1510, 4'h9, V_FETCH}, {20'hE1510, 4'h9, V_DEC},
          {20'hE1510, 4'h9, V_EXR_SUB}, {20'hE1510, 4'h9, V_WB_NONE},
          {20'hE0123, 4'h6, V_FETCH}, {20'hE0123, 4'h6, V_DEC},
          {20'hE0123, 4'h6, V_EXR_AND}, {20'hE0123, 4'h6, V_WB_W},
          {20'h0A000, 4'h0, V_FETCH}, {20'h0A000, 4'h0, V_DEC}, {20'h0A000, 4'h0, V_BR_T},
          {20'h2A000, 4'h0, V_FETCH}, {20'h2A000, 4'h0, V_DEC}, {20'h2A000, 4'h0, V_BR_N},
          {20'h6A000, 4'h0, V_FETCH}, {20'h6A000, 4'h0, V_DEC}, {20'h6A000, 4'h0, V_BR_T},
          {20'hFA000, 4'h0, V_FETCH}, {20'hFA000, 4'h0, V_DEC}, {20'hFA000, 4'h0, V_BR_N},
          {20'hEC000, 4'h0, V_FETCH}, {20'hEC000, 4'h0, V_DEC_DONE}};
    foreach (t[i]) begin
      Instr = t[i][40:21]; ALUFlags = t[i][20:17];
      #1; n_cmp++;
      if (ctrl !== t[i][16:0]) begin
        n_err++;
        $display("FAIL ands cycle %0d: ctrl=%b expected %b", i, ctrl, t[i][16:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [40:0] t [$];
    logic [40:0] p [$];
    t = '{{20'hE5902, 4'h0, V_FETCH}, {20'hE5902, 4'h0, V_DEC}, {20'hE5902, 4'h0, V_MADR}};
    foreach (t[i]) begin
      Instr = t[i][40:21]; ALUFlags = t[i][20:17];
      #1; n_cmp++;
      if (ctrl !== t[i][16:0]) begin
        n_err++;
        $display("FAIL reset_mid cycle %0d: ctrl=%b expected %b", i, ctrl, t[i][16:0]);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1; n_cmp++;
    if (ctrl !== V_MRD) begin
      n_err++;
      $display("FAIL reset_mid_memrd: ctrl=%b expected %b", ctrl, V_MRD);
    end
    @(posedge clk); #1; n_cmp++;
    if (ctrl !== V_FETCH_RST) begin
      n_err++;
      $display("FAIL reset_mid_fetch: ctrl=%b expected %b", ctrl, V_FETCH_RST);
    end
    reset = 1'b0;
    // Flags back to 0000: EQ and VS fail, NE passes
    p = '{{20'h0A000, 4'h0, V_FETCH}, {20'h0A000, 4'h0, V_DEC}, {20'h0A000, 4'h0, V_BR_N},
          {20'h6A000, 4'h0, V_FETCH}, {20'h6A000, 4'h0, V_DEC}, {20'h6A000, 4'h0, V_BR_N},
          {20'h1A000, 4'h0, V_FETCH}, {20'h1A000, 4'h0, V_DEC}, {20'h1A000, 4'h0, V_BR_T}};
    foreach (p[i]) begin
      Instr = p[i][40:21]; ALUFlags = p[i][20:17];
      #1; n_cmp++;
      if (ctrl !== p[i][16:0]) begin
        n_err++;
        $display("FAIL flags_after_reset cycle %0d: ctrl=%b expected %b", i, ctrl, p[i][16:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_subs_addne();
    test_cmp_beq();
    test_mem();
    test_ands();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
